// File: rtl/reg_pipeline.sv
// Elastic valid/ready register pipeline: DEPTH stages of N-bit data with
// collapsing bubbles, synchronous flush and an occupancy count.

module reg_pipeline_stage #(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         resetN,
    input  logic         flush,
    input  logic         load,
    input  logic         up_valid,
    input  logic [N-1:0] up_data,
    output logic         valid,
    output logic [N-1:0] data
);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (flush)
                valid <= 1'b0;
            else if (load)
                valid <= up_valid;
            // data only moves with a real word so bubbles never overwrite it
            if (load && up_valid)
                data <= up_data;
        end
    end

endmodule

module reg_pipeline #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       resetN,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [N-1:0]               in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [N-1:0]               out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);

    // chain_*[0] is the input side; chain_*[i+1] is the output of stage i
    logic [DEPTH:0]        chain_v;
    logic [DEPTH:0][N-1:0] chain_d;
    logic [DEPTH:0]        r;
    logic                  in_fire;
    logic                  out_fire;

    assign chain_v[0] = in_valid && !flush;
    assign chain_d[0] = in_data;

    // A stage can load when empty or when the stage after it is moving.
    always_comb begin
        r        = '0;
        r[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--)
            r[i] = !chain_v[i+1] || r[i+1];
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        reg_pipeline_stage #(.N(N)) u_stage (
            .clock    (clock),
            .resetN   (resetN),
            .flush    (flush),
            .load     (r[i]),
            .up_valid (chain_v[i]),
            .up_data  (chain_d[i]),
            .valid    (chain_v[i+1]),
            .data     (chain_d[i+1])
        );
    end

    assign in_ready  = r[0] && !flush;
    assign out_valid = chain_v[DEPTH];
    assign out_data  = chain_d[DEPTH];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN)
            count <= '0;
        else if (flush)
            count <= '0;
        else
            count <= count + CW'(in_fire) - CW'(out_fire);
    end

endmodule

// File: tb/tb_reg_pipeline.sv
// Directed bench for reg_pipeline: DEPTH=4 instance for streaming, stall,
// bubble collapse and flush; DEPTH=1 instance for latency and async reset.

module tb_reg_pipeline;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    // DEPTH=4 instance
    logic        rst_a, flush_a, iv_a, ir_a, ov_a, or_a;
    logic [31:0] id_a, od_a;
    logic [2:0]  cnt_a;

    // DEPTH=1 instance
    logic        rst_b, flush_b, iv_b, ir_b, ov_b, or_b;
    logic [31:0] id_b, od_b;
    logic        cnt_b;

    int checks   = 0;
    int failures = 0;

    reg_pipeline #(.N(32), .DEPTH(4)) u_dut_a (
        .clock(clock), .resetN(rst_a), .flush(flush_a),
        .in_valid(iv_a), .in_data(id_a), .in_ready(ir_a),
        .out_valid(ov_a), .out_data(od_a), .out_ready(or_a), .count(cnt_a)
    );

    reg_pipeline #(.N(32), .DEPTH(1)) u_dut_b (
        .clock(clock), .resetN(rst_b), .flush(flush_b),
        .in_valid(iv_b), .in_data(id_b), .in_ready(ir_b),
        .out_valid(ov_b), .out_data(od_b), .out_ready(or_b), .count(cnt_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        rst_a = 1'b0; flush_a = 1'b0; iv_a = 1'b0; id_a = '0; or_a = 1'b0;
        rst_b = 1'b0; flush_b = 1'b0; iv_b = 1'b0; id_b = '0; or_b = 1'b0;
        tick();
        chk("rst_out_valid", ov_a, 0);
        chk("rst_out_data",  od_a, 0);
        chk("rst_count",     cnt_a, 0);
        chk("rst_in_ready",  ir_a, 1);
        chk("rst_b_out_valid", ov_b, 0);

        // first word: latency check
        rst_a = 1'b1; rst_b = 1'b1;
        or_a = 1'b1; iv_a = 1'b1; id_a = 32'd1;
        tick();
        iv_a = 1'b0;
        chk("lat_count1", cnt_a, 1);
        chk("lat_ov_t0", ov_a, 0);
        tick(); chk("lat_ov_t1", ov_a, 0);
        tick(); chk("lat_ov_t2", ov_a, 0);
        tick(); chk("lat_ov_t3", ov_a, 1);
        chk("lat_od_t3", od_a, 1);
        tick(); chk("lat_drained", ov_a, 0);
        chk("lat_count0", cnt_a, 0);

        // streaming 1..20 back-to-back
        for (int c = 0; c < 26; c++) begin
            iv_a = (c < 20);
            id_a = 32'(c + 1);
            tick();
            chk($sformatf("strm_ov_%0d", c), ov_a, (c >= 3 && c <= 22));
            if (c >= 3 && c <= 22) chk($sformatf("strm_od_%0d", c), od_a, 64'(c - 2));
            if (c >= 3 && c <= 19) chk($sformatf("strm_cnt_%0d", c), cnt_a, 4);
        end
        chk("strm_empty", cnt_a, 0);

        // backpressure: only 4 of 6 accepted while stalled
        or_a = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            iv_a = 1'b1; id_a = 32'(k);
            tick();
        end
        id_a = 32'd5;
        #1;
        chk("bp_in_ready_full", ir_a, 0);
        chk("bp_count_full", cnt_a, 4);
        chk("bp_od_head", od_a, 1);
        tick();
        chk("bp_hold_count", cnt_a, 4);
        chk("bp_hold_od", od_a, 1);
        or_a = 1'b1;
        #1;
        chk("bp_in_ready_release", ir_a, 1);
        tick(); chk("bp_od2", od_a, 2); chk("bp_cnt_a", cnt_a, 4);
        id_a = 32'd6;
        tick(); chk("bp_od3", od_a, 3);
        iv_a = 1'b0;
        tick(); chk("bp_od4", od_a, 4); chk("bp_cnt3", cnt_a, 3);
        tick(); chk("bp_od5", od_a, 5);
        tick(); chk("bp_od6", od_a, 6); chk("bp_ov6", ov_a, 1);
        tick(); chk("bp_empty_ov", ov_a, 0); chk("bp_empty_cnt", cnt_a, 0);

        // bubble collapse behind a stalled output
        or_a = 1'b0;
        iv_a = 1'b1; id_a = 32'd7;
        tick();
        iv_a = 1'b0;
        tick(); tick();
        iv_a = 1'b1; id_a = 32'd8;
        tick();
        iv_a = 1'b0;
        tick(); tick();
        chk("bub_count", cnt_a, 2);
        chk("bub_od7", od_a, 7);
        or_a = 1'b1;
        tick(); chk("bub_ov8", ov_a, 1); chk("bub_od8", od_a, 8);
        tick(); chk("bub_empty", ov_a, 0); chk("bub_cnt0", cnt_a, 0);

        // flush a full pipeline while the head transfers
        or_a = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            iv_a = 1'b1; id_a = 32'(k);
            tick();
        end
        or_a = 1'b1; flush_a = 1'b1; id_a = 32'd99;
        #1;
        chk("fl_in_ready", ir_a, 0);
        chk("fl_head_ov", ov_a, 1);
        chk("fl_head_od", od_a, 1);
        tick();
        flush_a = 1'b0; iv_a = 1'b0;
        chk("fl_count", cnt_a, 0);
        chk("fl_ov", ov_a, 0);
        iv_a = 1'b1; id_a = 32'd9;
        tick();
        iv_a = 1'b0;
        tick(); tick();
        chk("fl9_not_yet", ov_a, 0);
        tick();
        chk("fl9_ov", ov_a, 1);
        chk("fl9_od", od_a, 9);
        tick();
        chk("fl9_drained", cnt_a, 0);

        // DEPTH=1: single register behaviour
        or_b = 1'b1; iv_b = 1'b1; id_b = 32'd5;
        tick();
        chk("d1_ov5", ov_b, 1); chk("d1_od5", od_b, 5); chk("d1_cnt1", cnt_b, 1);
        id_b = 32'd6;
        #1; chk("d1_in_ready_full_flow", ir_b, 1);
        tick();
        chk("d1_od6", od_b, 6); chk("d1_ov6", ov_b, 1);
        iv_b = 1'b0;
        tick();
        chk("d1_empty", ov_b, 0);
        iv_b = 1'b1; id_b = 32'd7;
        tick();
        iv_b = 1'b0;
        chk("d1_ov7", ov_b, 1);
        #2;
        rst_b = 1'b0;
        #1;
        chk("d1_async_ov", ov_b, 0);
        chk("d1_async_od", od_b, 0);
        chk("d1_async_cnt", cnt_b, 0);
        tick();
        rst_b = 1'b1;
        tick();
        chk("d1_post_reset_ov", ov_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_pipeline.md
# reg_pipeline

Parametrised elastic register pipeline: `N`-bit data passes through `DEPTH` register stages under a valid/ready handshake with full throughput, per-stage stall, synchronous flush and an occupancy count. It is the successor to the fixed 32-bit D register. With `DEPTH=1` and `out_ready` tied high it behaves as a width-`N` register with a qualifying valid bit. It sits between any two valid/ready blocks that need registered timing isolation.

## Interface
- `N`, 32: data width, ≥1.
- `DEPTH`, 4: number of register stages, ≥1.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous discard of all held words.
- `in_valid`  in  1  upstream word present.
- `in_data`  in  N  upstream word.
- `in_ready`  out  1  pipeline accepts `in_data` this cycle.
- `out_valid`  out  1  stage `DEPTH-1` holds a word.
- `out_data`  out  N  word in stage `DEPTH-1`.
- `out_ready`  in  1  downstream accepts the output word.
- `count`  out  $clog2(DEPTH+1)  number of valid stages.

## Operation
- Each stage i (0..DEPTH-1) holds `v[i]` and `d[i]`.
- Stage 0 is fed by the input. Stage `DEPTH-1` drives `out_valid` and `out_data`.
- Ready chain (combinational): `r[DEPTH] = out_ready`; `r[i] = !v[i] || r[i+1]`; `in_ready = r[0] && !flush`.
- Stage i loads when `r[i]` is 1:
  - `v[i] <= v[i-1]`, with `v[-1] = in_valid && !flush`.
  - `d[i] <= d[i-1]` only when the upstream valid is 1; otherwise `d[i]` holds its value.
- When `r[i]` is 0, the stage holds both `v[i]` and `d[i]`.
- Bubbles collapse: a stalled output does not block empty upstream stages from filling.
- Transfer definitions:
  - `in_fire = in_valid && in_ready`.
  - `out_fire = out_valid && out_ready`.
- Count update:
  - `count <= count + in_fire - out_fire`.
  - On `flush`, `count <= 0`.
  - `count` must always equal the popcount of `v`.
- Flush:
  - During a `flush` cycle an `out_fire` still counts as a completed transfer.
  - On the following edge all `v` bits clear and `count` becomes 0.
  - `d` registers are not cleared.
  - `in_ready` is 0 during `flush`, so no input is taken.
- Ordering: words leave in acceptance order. There is no loss or duplication except by `flush`.
- Protocol rule on upstream: once `in_valid` is raised with `in_ready` low, `in_valid` and `in_data` hold until accepted. Downstream is held to the same rule.
- `out_data` is undefined while `out_valid` is 0. The bench must not check it then.

## Timing
- Reset (`resetN` low, asynchronous):
  - All `v` = 0, all `d` = 0, `count` = 0, `out_valid` = 0, `out_data` = 0.
  - `in_ready` = 1 as soon as `flush` is low.
- Reset release is synchronous to `clock` at the system level. The first transfer is possible on the first rising edge after `resetN` goes high.
- Latency: a word accepted at edge t, with no stall, presents `out_valid` = 1 after edge t+DEPTH-1. It is available for `out_fire` in the cycle following that edge, i.e. DEPTH cycles after acceptance.
- Throughput: one word per cycle with `out_ready` held high.
- Full: all `v` = 1 and `out_ready` = 0 gives `in_ready` = 0. With all stages full and `out_ready` = 1, in-and-out in the same cycle is allowed; `count` stays at DEPTH.
- Empty: with all `v` = 0, `out_valid` = 0 and `count` = 0; `out_ready` is don't-care.
- Reset mid-stream: all in-flight words are lost. There is no partial output.
- Reset has priority over `flush`; `flush` has priority over input.

## Test plan
- Reset check, `N`=32, `DEPTH`=4: assert `resetN`=0 for 1 cycle → `out_valid`=0, `out_data`=0, `count`=0, `in_ready`=1. Release, then push `d`=1 → `out_valid` rises 4 cycles later with `out_data`=1.
- Streaming: `out_ready`=1, push 1..20 back-to-back → 20 outputs in order, one per cycle, first at acceptance+4, `count` steady at 4.
- Backpressure and fill: `out_ready`=0, push 1..6 → accepts exactly 4, `in_ready`=0 after the 4th, `count`=4. Raise `out_ready` → outputs 1,2,3,4 then 5,6 in order.
- Bubble collapse: push 7, idle 2 cycles, push 8, with `out_ready`=0 → `count`=2. Release `out_ready` → 7 then 8 on consecutive cycles.
- Flush: full pipeline holding 1..4, `out_ready`=1, `flush`=1 for one cycle → 1 transfers in that cycle. Next cycle `count`=0, `out_valid`=0. Word 9 pushed afterwards appears as the next output.
- `DEPTH`=1: `out_ready`=1, push 5,6 → each appears 1 cycle after acceptance. Async reset mid-stream clears `out_valid` immediately, without waiting for a clock edge.
